// File: rtl/my_uart_rx.sv
// MyUart serial receiver: start bit, 8 data bits MSB first, one or more stop bits,
// sampled at mid-bit by an oversampling clock and handed over through a Valid/RdAck level handshake.
module my_uart_rx #(
    parameter int OVERSAMPLE = 16   // ReceivingCLK cycles per bit; even and >= 4
) (
    input  logic       ReceivingCLK,
    input  logic       Init,
    input  logic       EN,
    input  logic       RxD,
    input  logic       RdAck,
    output logic [7:0] RxData,
    output logic       Valid,
    output logic       FrameErr,
    output logic       Overrun,
    output logic       Busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    logic [1:0]    sync_reg;
    logic          rx_s;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shreg_reg;
    logic          stop_bit_reg;
    logic [7:0]    rx_data_reg;
    logic          valid_reg;
    logic          frame_err_reg;
    logic          overrun_reg;
    logic          busy_reg;

    // Two-flop synchronizer; idles high so a reset never looks like a start edge.
    always_ff @(posedge ReceivingCLK) begin
        if (Init) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], RxD};
        end
    end

    assign rx_s = sync_reg[1];

    always_ff @(posedge ReceivingCLK) begin
        if (Init) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= 3'd0;
            shreg_reg     <= 8'h00;
            stop_bit_reg  <= 1'b0;
            rx_data_reg   <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            // A load in S_DONE later in this block wins over the ack clear.
            if (RdAck && valid_reg) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (EN && !rx_s) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        if (rx_s) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg   <= S_DATA;
                            cnt_reg     <= '0;
                            bit_idx_reg <= 3'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg     <= '0;
                        shreg_reg   <= {shreg_reg[6:0], rx_s};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= S_STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        stop_bit_reg <= rx_s;
                        state_reg    <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                // Stop bit was captured on the previous edge; outputs update here.
                S_DONE: begin
                    cnt_reg <= '0;
                    if (stop_bit_reg) begin
                        rx_data_reg <= shreg_reg;
                        valid_reg   <= 1'b1;
                        if (valid_reg && !RdAck) begin
                            overrun_reg <= 1'b1;
                        end
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= S_BREAK;
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign RxData   = rx_data_reg;
    assign Valid    = valid_reg;
    assign FrameErr = frame_err_reg;
    assign Overrun  = overrun_reg;
    assign Busy     = busy_reg;

endmodule

// File: tb/tb_my_uart_rx.sv
// Directed and randomized frames against a byte-level model of the receiver's
// handshake, overrun and framing rules.
module tb_my_uart_rx;
    localparam int OS = 16;

    logic       ReceivingCLK = 1'b0;
    logic       Init  = 1'b1;
    logic       EN    = 1'b0;
    logic       RxD   = 1'b1;
    logic       RdAck = 1'b0;
    logic [7:0] RxData;
    logic       Valid;
    logic       FrameErr;
    logic       Overrun;
    logic       Busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_data    = 8'h00;
    logic       m_valid   = 1'b0;
    logic       m_overrun = 1'b0;

    my_uart_rx #(.OVERSAMPLE(OS)) dut (
        .ReceivingCLK(ReceivingCLK),
        .Init        (Init),
        .EN          (EN),
        .RxD         (RxD),
        .RdAck       (RdAck),
        .RxData      (RxData),
        .Valid       (Valid),
        .FrameErr    (FrameErr),
        .Overrun     (Overrun),
        .Busy        (Busy)
    );

    always #5 ReceivingCLK = ~ReceivingCLK;

    task automatic tick();
        @(posedge ReceivingCLK);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check8({tag, ".data"}, RxData, m_data);
        check1({tag, ".valid"}, Valid, m_valid);
        check1({tag, ".overrun"}, Overrun, m_overrun);
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) tick();
    endtask

    task automatic ack_pulse();
        RdAck = 1'b1;
        tick();
        RdAck = 1'b0;
        m_valid = 1'b0;
        check1("ack.valid", Valid, m_valid);
        $display("ack: Valid=%b", Valid);
    endtask

    // Line bit k (0=start, 1..8 data MSB first, 9=stop) is captured from edge t0+k*OS;
    // iteration c ends just after edge t0+c.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int ack_mode,
                              input logic expect_rx, input int abort_at, input int en_drop_at);
        logic [9:0] bitv;
        logic       busy_seen;
        logic       ack;
        bitv[0] = 1'b0;
        for (int k = 1; k <= 8; k++) bitv[k] = data[8 - k];
        bitv[9] = stop_val;
        busy_seen = 1'b0;
        for (int c = 0; c < 10 * OS; c++) begin
            if (c == abort_at) begin
                Init = 1'b1;
                RxD  = 1'b1;
                tick();
                Init = 1'b0;
                m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
                check_model("abort");
                check1("abort.busy", Busy, 1'b0);
                check1("abort.ferr", FrameErr, 1'b0);
                $display("frame %02h aborted by Init at cycle %0d", data, c);
                return;
            end
            if (c == en_drop_at) EN = 1'b0;
            ack   = (ack_mode == 2) && (c == 155);
            RxD   = bitv[c / OS];
            RdAck = ack;
            tick();
            busy_seen |= Busy;
            if (expect_rx) begin
                if (c == 154) begin
                    check1("pre.busy", Busy, 1'b1);
                    check1("pre.valid", Valid, m_valid);
                    check1("pre.ferr", FrameErr, 1'b0);
                end
                if (c == 155) begin
                    if (stop_val) begin
                        if (m_valid && !ack) m_overrun = 1'b1;
                        m_valid = 1'b1;
                        m_data  = data;
                    end else if (ack) begin
                        m_valid = 1'b0;
                    end
                    check_model("load");
                    check1("load.ferr", FrameErr, !stop_val);
                    check1("load.busy", Busy, !stop_val);
                end
                if (c == 156) check1("post.ferr", FrameErr, 1'b0);
            end
        end
        RdAck = 1'b0;
        if (en_drop_at >= 0) EN = 1'b1;
        if (!expect_rx) begin
            check1("noen.busy", busy_seen, 1'b0);
            check_model("noen");
        end
        $display("frame %02h stop=%b ack_mode=%0d -> RxData=%02h Valid=%b Overrun=%b",
                 data, stop_val, ack_mode, RxData, Valid, Overrun);
    endtask

    // Line is already low from a bad stop bit; hold it, then release.
    task automatic break_recover(input int n);
        RxD = 1'b0;
        repeat (n) tick();
        check1("break.busy_held", Busy, 1'b1);
        check1("break.ferr_held", FrameErr, 1'b0);
        RxD = 1'b1;
        tick();
        tick();
        check1("break.busy_2", Busy, 1'b1);
        tick();
        check1("break.busy_3", Busy, 1'b0);
        check_model("break");
    endtask

    initial begin
        int n;
        int en_at;
        logic [7:0] d;
        logic sb;
        int mode;

        Init = 1'b1; EN = 1'b0; RxD = 1'b1; RdAck = 1'b0;
        repeat (3) tick();
        check_model("reset");
        check1("reset.busy", Busy, 1'b0);
        check1("reset.ferr", FrameErr, 1'b0);
        Init = 1'b0; EN = 1'b1;
        idle(4);

        // Basic frame, then ack
        send_frame(8'hA5, 1'b1, 0, 1'b1, -1, -1);
        idle(2);
        ack_pulse();

        // Glitch shorter than half a bit
        n = 0;
        for (int i = 0; i < 24; i++) begin
            RxD = (i < 4) ? 1'b0 : 1'b1;
            tick();
            if (Busy) n++;
        end
        check8("glitch.busy_cycles", 8'(n), 8'd8);
        check_model("glitch");
        $display("glitch: busy for %0d cycles", n);
        idle(4);
        send_frame(8'h3C, 1'b1, 0, 1'b1, -1, -1);
        idle(2);
        ack_pulse();

        // Framing error with a held-low line
        send_frame(8'h3C, 1'b0, 0, 1'b1, -1, -1);
        break_recover(40);
        idle(3);
        send_frame(8'h81, 1'b1, 0, 1'b1, -1, -1);
        idle(2);
        ack_pulse();

        // Overrun, then Init clears everything
        send_frame(8'h11, 1'b1, 0, 1'b1, -1, -1);
        idle(3);
        send_frame(8'h22, 1'b1, 0, 1'b1, -1, -1);
        idle(2);
        Init = 1'b1;
        tick();
        Init = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
        check_model("init");
        check1("init.busy", Busy, 1'b0);
        check1("init.ferr", FrameErr, 1'b0);
        idle(2);

        // Ack on the same edge as a load
        send_frame(8'h44, 1'b1, 0, 1'b1, -1, -1);
        idle(2);
        send_frame(8'h55, 1'b1, 2, 1'b1, -1, -1);
        idle(2);
        ack_pulse();

        // Init during data bit 4, then a clean frame
        send_frame(8'hF0, 1'b1, 0, 1'b1, 4 * OS + OS / 2, -1);
        idle(4);
        send_frame(8'h0F, 1'b1, 0, 1'b1, -1, -1);
        idle(2);
        ack_pulse();

        // Disabled receiver ignores a whole frame
        EN = 1'b0;
        idle(2);
        send_frame(8'h99, 1'b1, 0, 1'b0, -1, -1);
        EN = 1'b1;
        idle(2);

        // Randomized frames, gaps, acks, EN drops and bad stop bits
        for (int f = 0; f < 16; f++) begin
            d    = 8'($urandom);
            sb   = ($urandom_range(0, 5) != 0);
            mode = int'($urandom_range(0, 2));
            en_at = -1;
            if ($urandom_range(0, 1) == 1) en_at = int'($urandom_range(20, 140));
            if ($urandom_range(0, 3) == 0) ack_pulse();
            send_frame(d, sb, mode, 1'b1, -1, en_at);
            if (!sb) break_recover(int'($urandom_range(0, 20)));
            idle(int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/my_uart_rx.md
Name: my_uart_rx

Overview:
- Serial receiver matching the MyUart transmit format.
- Frame: idle high; one start bit (0); 8 data bits MSB first; one or more stop bits (1).
- Samples the asynchronous RxD line with an oversampling clock and presents each byte on a parallel port with a level Valid/RdAck handshake.
- Sits between the board receive pin and the command/capture logic; also serves as the loopback checker for the transmitter.

Parameters:
- OVERSAMPLE, 16: ReceivingCLK cycles per bit. Must be even and ≥4. Counter width is clog2(OVERSAMPLE).

Ports:
- ReceivingCLK  in  1  oversampling clock, OVERSAMPLE× bit rate; all logic on posedge
- Init  in  1  synchronous active-high reset
- EN  in  1  receive enable; sampled only in IDLE
- RxD  in  1  asynchronous serial input, idle high
- RdAck  in  1  consumer acknowledge; clears Valid
- RxData  out  8  last good byte; held until the next good byte
- Valid  out  1  level; RxData holds an unread byte
- FrameErr  out  1  one-cycle pulse when the stop bit is sampled 0
- Overrun  out  1  sticky; a byte was loaded while Valid was set and not acked
- Busy  out  1  high in any state other than IDLE

Behaviour:
- RxD passes through a 2-flop synchronizer (reset value 1) to give RxS. All decisions use RxS only.
- Init, on a clock edge, overrides everything:
  - state=IDLE; counters=0; shift register=0
  - RxData=0, Valid=0, FrameErr=0, Overrun=0, Busy=0; synchronizer flops=1
  - Init mid-frame abandons the frame: no Valid, no FrameErr.
- States:
  - IDLE: if EN && RxS==0 → START, with cnt=0.
  - START: cnt increments each cycle. At cnt==OVERSAMPLE/2-1:
    - RxS==1 → false start, back to IDLE.
    - RxS==0 → DATA, with cnt=0 and bitidx=0.
  - DATA: cnt wraps at OVERSAMPLE-1. On each wrap: shift RxS in at the LSB (shreg <= {shreg[6:0],RxS}); bitidx++. After the 8th bit → STOP, with cnt=0.
  - STOP: at cnt==OVERSAMPLE-1 sample RxS.
    - RxS==1 → RxData<=shreg; Valid<=1; → IDLE.
    - RxS==0 → FrameErr=1 for one cycle; RxData and Valid unchanged; → BREAK.
  - BREAK: wait for RxS==1, then → IDLE. A held-low line never produces bytes.
- Sample timing:
  - t0 is the edge on which the first sync flop captures RxD=0.
  - Bit k (start=0, data 1..8, stop=9) is sampled at edge t0+2+OVERSAMPLE/2+k·OVERSAMPLE.
  - Valid is high after the following edge. With OVERSAMPLE=16, Valid rises at edge t0+155.
- Handshake:
  - RdAck while Valid=1 clears Valid at the next edge. RdAck while Valid=0 is ignored.
  - Load and RdAck on the same edge: Valid stays 1, RxData takes the new byte, no Overrun.
  - Load with Valid=1 and no RdAck: RxData is overwritten and Overrun<=1. Overrun clears only on Init.
- EN dropping mid-frame has no effect; the frame completes. EN is not re-checked until IDLE.
- Back-to-back frames: the transmitter's minimum is one stop bit. The receiver returns to IDLE at the stop-bit midpoint, so the next start edge is always detected.
- Tolerates ±3% bit-rate mismatch with OVERSAMPLE=16.

Test Plan:
1. OVERSAMPLE=16, EN=1. Send 0xA5 (bits 1,0,1,0,0,1,0,1) at 16 clk/bit → Valid rises at t0+155, RxData=0xA5, FrameErr=0, Overrun=0, Busy falls together with the Valid rise. Then pulse RdAck → Valid=0 at the next edge.
2. Glitch: RxD low for 4 clocks, then high → Busy high for about 8 cycles, back to IDLE, Valid stays 0. A following 0x3C frame is received correctly.
3. Framing error: send 0x3C with stop bit 0, hold RxD low 40 clocks, release → one FrameErr pulse, Valid=0, RxData unchanged. The next frame 0x81 → RxData=0x81, Valid=1.
4. Overrun, then Init: send 0x11 and 0x22 without RdAck → RxData=0x22, Valid=1, Overrun=1. Assert Init → all outputs 0.
5. Same-edge ack: assert RdAck exactly on the edge that loads the second byte 0x55 → Valid=1, RxData=0x55, Overrun=0.
6. Init asserted during data bit 4 of 0xF0, then a full 0x0F frame → no output from the aborted frame, RxData=0x0F, Valid=1. Also EN=0 in IDLE with a full frame sent → nothing received, Busy stays 0.
